bcd_countdown_timer: RTL and testbench

//  Parametrised BCD countdown timer; successor of the fixed 60 s game timer. Adds run/pause control,

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_dec_add.sv | 62 ++++++
 rtl/bcd_countdown_timer.sv | 145 ++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state type and BCD digit helper for the BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_RUN     = 2'd1,
        T_PAUSED  = 2'd2,
        T_EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        logic [3:0] res;
        if (digit > BCD_MAX_DIGIT) begin
            res = BCD_MAX_DIGIT;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_dec_add.sv
// Combinational BCD datapath: optional decrement by one, then saturating add.
module bcd_dec_add
    import timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic [4*DIGITS-1:0] addend,
    input  logic                dec_en,
    output logic [4*DIGITS-1:0] result,
    output logic                is_zero
);

    logic [4*DIGITS-1:0] dec_s;
    logic [4*DIGITS-1:0] sum_s;

    // Borrow ripples through zero digits; a zero value is never decremented.
    always_comb begin
        logic       borrow;
        logic [3:0] digit;
        dec_s  = value;
        borrow = dec_en && (value != '0);
        for (int i = 0; i < DIGITS; i++) begin
            digit = value[4*i +: 4];
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_s[4*i +: 4] = BCD_MAX_DIGIT;
                end else begin
                    dec_s[4*i +: 4] = digit - 4'd1;
                    borrow          = 1'b0;
                end
            end else begin
                dec_s[4*i +: 4] = digit;
            end
        end
    end

    // Per-digit add with decimal carry; a carry out of the top digit saturates.
    always_comb begin
        logic       carry;
        logic [4:0] dsum;
        sum_s = '0;
        carry = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dsum = {1'b0, dec_s[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'b0000, carry};
            if (dsum > 5'd9) begin
                dsum  = dsum - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum_s[4*i +: 4] = dsum[3:0];
        end
        if (carry) begin
            result = {DIGITS{BCD_MAX_DIGIT}};
        end else begin
            result = sum_s;
        end
        is_zero = (result == '0);
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer with run/pause control, runtime load, bonus add,
// warning threshold and one-cycle expiry / second pulses.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int                  CLK_FREQ   = 50_000_000,
    parameter int                  DIGITS     = 2,
    parameter logic [4*DIGITS-1:0] INIT_BCD   = 'h60,
    parameter logic [4*DIGITS-1:0] WARN_BCD   = 'h10,
    parameter int                  AUTO_START = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic                pause,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                add_en,
    input  logic [4*DIGITS-1:0] add_value,
    output logic [4*DIGITS-1:0] time_left,
    output logic                running,
    output logic                warning,
    output logic                time_up,
    output logic                expire_pulse,
    output logic                sec_tick
);

    localparam int                 PW          = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]      PRESC_MAX   = PW'(CLK_FREQ - 1);
    localparam timer_state_t       RESET_STATE = (AUTO_START != 0) ? T_RUN : T_IDLE;

    timer_state_t        state_q, state_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                expire_q, expire_d;
    logic                sec_tick_q, sec_tick_d;

    logic [4*DIGITS-1:0] load_cl_s;
    logic [4*DIGITS-1:0] add_cl_s;
    logic [4*DIGITS-1:0] addend_s;
    logic [4*DIGITS-1:0] sum_s;
    logic                is_zero_s;
    logic                dec_en_s;
    logic                pause_s;
    logic                start_s;
    logic                at_max_s;

    // Any digit above 9 on the load / bonus inputs is treated as 9.
    always_comb begin
        load_cl_s = '0;
        add_cl_s  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_cl_s[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
            add_cl_s[4*i +: 4]  = bcd_clamp(add_value[4*i +: 4]);
        end
    end

    assign at_max_s = (presc_q == PRESC_MAX);

    // Effective commands after priority (load > add_en > pause > start > tick).
    always_comb begin
        pause_s  = pause && !add_en && (state_q == T_RUN);
        start_s  = start && !pause && !add_en && (count_q != '0) &&
                   ((state_q == T_IDLE) || (state_q == T_PAUSED));
        dec_en_s = !load && !pause_s && (state_q == T_RUN) && at_max_s;
        if (add_en) begin
            addend_s = add_cl_s;
        end else begin
            addend_s = '0;
        end
    end

    bcd_dec_add #(
        .DIGITS (DIGITS)
    ) u_dec_add (
        .value   (count_q),
        .addend  (addend_s),
        .dec_en  (dec_en_s),
        .result  (sum_s),
        .is_zero (is_zero_s)
    );

    // Next-state, count and prescaler selection.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        sec_tick_d = dec_en_s;
        if (load) begin
            count_d = load_cl_s;
            presc_d = '0;
            state_d = T_IDLE;
        end else if (state_q == T_EXPIRED) begin
            if (add_en && (add_cl_s != '0)) begin
                state_d = T_RUN;
                presc_d = '0;
                count_d = sum_s;
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = sum_s;
            if ((state_q == T_RUN) && !pause_s) begin
                presc_d = at_max_s ? '0 : presc_q + PW'(1);
            end else begin
                presc_d = presc_q;
            end
            if (pause_s) begin
                state_d = T_PAUSED;
            end else if (start_s) begin
                state_d = T_RUN;
            end else if (dec_en_s && is_zero_s) begin
                state_d = T_EXPIRED;
            end else begin
                state_d = state_q;
            end
        end
        expire_d = (state_d == T_EXPIRED) && (state_q != T_EXPIRED);
    end

    // State, count, prescaler and pulse registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= RESET_STATE;
            count_q    <= INIT_BCD;
            presc_q    <= '0;
            expire_q   <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            expire_q   <= expire_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign time_left    = count_q;
    assign running      = (state_q == T_RUN);
    assign time_up      = (state_q == T_EXPIRED);
    assign warning      = (count_q != '0) && (count_q <= WARN_BCD) && (state_q != T_IDLE);
    assign expire_pulse = expire_q;
    assign sec_tick     = sec_tick_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: directed scenarios plus random
// stimulus against an integer-arithmetic reference model.
module tb_bcd_countdown_timer;

    localparam int CF    = 4;
    localparam int MAXV  = 99;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAUS = 2;
    localparam int S_EXP  = 3;

    logic       Clk;
    logic       Reset;
    logic       start, pause, load, add_en;
    logic [7:0] load_value, add_value;
    logic [7:0] time_left;
    logic       running, warning, time_up, expire_pulse, sec_tick;

    logic [11:0] tl3;
    logic        run3, warn3, up3, pulse3, tick3;
    logic        zero1;
    logic [11:0] zero12;

    typedef struct packed {
        logic [7:0] tl;
        logic       run;
        logic       warn;
        logic       tup;
        logic       pulse;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;

    int checks;
    int errors;

    int m_t;
    int m_presc;
    int m_st;
    bit m_pulse;
    bit m_tick;

    bcd_countdown_timer #(
        .CLK_FREQ   (CF),
        .DIGITS     (2),
        .INIT_BCD   (8'h60),
        .WARN_BCD   (8'h10),
        .AUTO_START (1)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .pause        (pause),
        .load         (load),
        .load_value   (load_value),
        .add_en       (add_en),
        .add_value    (add_value),
        .time_left    (time_left),
        .running      (running),
        .warning      (warning),
        .time_up      (time_up),
        .expire_pulse (expire_pulse),
        .sec_tick     (sec_tick)
    );

    assign zero1  = 1'b0;
    assign zero12 = 12'h000;

    bcd_countdown_timer #(
        .CLK_FREQ   (CF),
        .DIGITS     (3),
        .INIT_BCD   (12'h100),
        .WARN_BCD   (12'h010),
        .AUTO_START (1)
    ) dut3 (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (zero1),
        .pause        (zero1),
        .load         (zero1),
        .load_value   (zero12),
        .add_en       (zero1),
        .add_value    (zero12),
        .time_left    (tl3),
        .running      (run3),
        .warning      (warn3),
        .time_up      (up3),
        .expire_pulse (pulse3),
        .sec_tick     (tick3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int bcd2int(input logic [7:0] b);
        int hi;
        int lo;
        hi = int'(b[7:4]);
        lo = int'(b[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic void model_reset();
        m_t     = 60;
        m_presc = 0;
        m_st    = S_RUN;
        m_pulse = 1'b0;
        m_tick  = 1'b0;
    endfunction

    // One elapsed second in RUN: returns whether this cycle completes it.
    function automatic bit model_advance();
        bit fire;
        fire = 1'b0;
        if (m_st == S_RUN) begin
            fire    = (m_presc == CF - 1);
            m_presc = (m_presc + 1) % CF;
        end
        return fire;
    endfunction

    function automatic void model_step(input logic ld, input logic [7:0] lv,
                                       input logic ad, input logic [7:0] av,
                                       input logic st, input logic pa);
        int a;
        int prev;
        bit fire;
        prev   = m_st;
        m_tick = 1'b0;
        a      = bcd2int(av);
        if (ld) begin
            m_t     = bcd2int(lv);
            m_presc = 0;
            m_st    = S_IDLE;
        end else if (ad && (m_st == S_EXP)) begin
            if (a != 0) begin
                m_t     = sat(a);
                m_st    = S_RUN;
                m_presc = 0;
            end
        end else if (ad) begin
            fire = model_advance();
            if (fire && m_t > 0) m_t = m_t - 1;
            m_t = sat(m_t + a);
            if (fire) begin
                m_tick = 1'b1;
                if (m_t == 0) m_st = S_EXP;
            end
        end else if (pa) begin
            if (m_st == S_RUN) m_st = S_PAUS;
        end else if (st && (m_st == S_IDLE || m_st == S_PAUS)) begin
            if (m_t > 0) m_st = S_RUN;
        end else begin
            fire = model_advance();
            if (fire) begin
                if (m_t > 0) m_t = m_t - 1;
                m_tick = 1'b1;
                if (m_t == 0) m_st = S_EXP;
            end
        end
        m_pulse = (m_st == S_EXP) && (prev != S_EXP);
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.tl    = int2bcd(m_t);
        e.run   = (m_st == S_RUN);
        e.warn  = (m_t > 0) && (m_t <= 10) && (m_st != S_IDLE);
        e.tup   = (m_st == S_EXP);
        e.pulse = m_pulse;
        e.tick  = m_tick;
        exp_q.push_back(e);
    endfunction

    // Monitor: every cycle the DUT presents one output set, compared against the next expectation.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {time_left, running, warning, time_up, expire_pulse, sec_tick};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual tl=%h run=%b warn=%b up=%b pulse=%b tick=%b required tl=%h run=%b warn=%b up=%b pulse=%b tick=%b",
                         $time, mon_a.tl, mon_a.run, mon_a.warn, mon_a.tup, mon_a.pulse, mon_a.tick,
                         mon_e.tl, mon_e.run, mon_e.warn, mon_e.tup, mon_e.pulse, mon_e.tick);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc(input logic ld, input logic [7:0] lv, input logic ad,
                       input logic [7:0] av, input logic st, input logic pa);
        load       = ld;
        load_value = lv;
        add_en     = ad;
        add_value  = av;
        start      = st;
        pause      = pa;
        @(posedge Clk);
        model_step(ld, lv, ad, av, st, pa);
        push_exp();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset is raised between edges; outputs must take reset values without a clock edge.
    task automatic do_reset();
        @(negedge Clk);
        #1;
        load = 1'b0; add_en = 1'b0; start = 1'b0; pause = 1'b0;
        load_value = 8'h00; add_value = 8'h00;
        Reset = 1'b1;
        #1;
        chk("reset_time_left", {24'h0, time_left}, 32'h60);
        chk("reset_dig3", {20'h0, tl3}, 32'h100);
        chk("reset_flags", {28'h0, running, time_up, expire_pulse, sec_tick}, 32'h8);
        @(posedge Clk);
        model_reset();
        push_exp();
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r_ld, r_ad, r_st, r_pa;
        logic [7:0] r_lv, r_av;
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        load = 1'b0; add_en = 1'b0; start = 1'b0; pause = 1'b0;
        load_value = 8'h00; add_value = 8'h00;
        model_reset();

        do_reset();
        idle(4);
        chk("t1_after4", {24'h0, time_left}, 32'h59);
        chk("t6_dig3_100_to_099", {20'h0, tl3}, 32'h099);
        idle(36);
        chk("t1_after40", {24'h0, time_left}, 32'h50);
        idle(4);
        chk("t1_borrow44", {24'h0, time_left}, 32'h49);
        chk("t6_dig3_44", {20'h0, tl3}, 32'h089);

        cyc(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_load_idle", {31'h0, running}, 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(4);
        chk("t2_01", {24'h0, time_left}, 32'h01);
        chk("t2_warning", {31'h0, warning}, 32'h1);
        idle(4);
        chk("t2_00", {24'h0, time_left}, 32'h00);
        chk("t2_time_up", {31'h0, time_up}, 32'h1);
        chk("t2_pulse", {31'h0, expire_pulse}, 32'h1);
        idle(1);
        chk("t2_pulse_once", {31'h0, expire_pulse}, 32'h0);
        idle(6);
        chk("t2_hold_zero", {24'h0, time_left}, 32'h00);

        cyc(1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(10);
        chk("t3_paused_hold", {24'h0, time_left}, 32'h30);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        chk("t3_no_tick_yet", {24'h0, time_left}, 32'h30);
        idle(1);
        chk("t3_resume_tick", {24'h0, time_left}, 32'h29);

        cyc(1'b1, 8'h95, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
        chk("t4_saturate", {24'h0, time_left}, 32'h99);
        cyc(1'b1, 8'h31, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(4);
        chk("t4_at_30", {24'h0, time_left}, 32'h30);
        idle(3);
        cyc(1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0);
        chk("t4_add_on_tick", {24'h0, time_left}, 32'h34);
        chk("t4_sec_tick", {31'h0, sec_tick}, 32'h1);
        cyc(1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 8'hA3, 1'b0, 1'b0);
        chk("t4_clamp_add", {24'h0, time_left}, 32'h98);

        cyc(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(4);
        chk("t5_expired", {31'h0, time_up}, 32'h1);
        cyc(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t5_add0_stays", {31'h0, time_up}, 32'h1);
        cyc(1'b0, 8'h00, 1'b1, 8'h15, 1'b0, 1'b0);
        chk("t5_revive_up", {31'h0, time_up}, 32'h0);
        chk("t5_revive_tl", {24'h0, time_left}, 32'h15);
        chk("t5_revive_run", {31'h0, running}, 32'h1);

        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("start_pause_same", {31'h0, running}, 32'h0);

        idle(5);
        do_reset();
        idle(4);
        chk("t6_after_reset", {24'h0, time_left}, 32'h59);

        for (int i = 0; i < 1500; i++) begin
            r_ld = ($urandom_range(0, 99) < 3);
            r_ad = ($urandom_range(0, 99) < 5);
            r_pa = ($urandom_range(0, 99) < 5);
            r_st = ($urandom_range(0, 99) < 12);
            r_lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 15));
            r_av = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 20));
            cyc(r_ld, r_lv, r_ad, r_av, r_st, r_pa);
        end
        idle(2);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge Clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
